serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice walks the operands LSB-first,
// producing a registered sum and carry after WIDTH shift cycles.

module half_adder (
  input  logic a,
  input  logic b,
  output logic S,
  output logic C
);
  assign S = a ^ b;
  assign C = a & b;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_d;
  logic             carry_q, carry_d, cout_d, busy_d, done_d;
  logic             ha0_s, ha0_c, fa_s, ha1_c, fa_c;

  // Full adder on the operand LSBs and the running carry
  half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]),  .S(ha0_s), .C(ha0_c));
  half_adder u_ha1 (.a(ha0_s),  .b(carry_q), .S(fa_s),  .C(ha1_c));
  assign fa_c = ha0_c | ha1_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum     <= sum_d;
      cout    <= cout_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state; busy/done are registered from the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum;
    cout_d  = cout;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = WIDTH'({fa_s, res_q} >> 1);
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_d;
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH 8, 1 and 4.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s8 = 1'b0, s1 = 1'b0, s4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       a1 = 1'b0, b1 = 1'b0, sum1;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy8, done8, cout8, busy1, done1, cout1, busy4, done4, cout4;

  int         n_chk = 0;
  int         n_err = 0;
  int         sel = 0;
  logic [7:0] last_sum [3];
  logic       last_cout [3];
  logic       cur_busy, cur_done, cur_cout;
  logic [7:0] cur_sum;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
                                .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
                                .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
  serial_adder #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
                                .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));

  always_comb begin
    cur_busy = busy8;
    cur_done = done8;
    cur_sum  = sum8;
    cur_cout = cout8;
    case (sel)
      1: begin cur_busy = busy1; cur_done = done1; cur_sum = 8'(sum1); cur_cout = cout1; end
      2: begin cur_busy = busy4; cur_done = done4; cur_sum = 8'(sum4); cur_cout = cout4; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic [7:0] av, input logic [7:0] bv, input logic st);
    case (s)
      0:       begin a8 = av;      b8 = bv;      s8 = st; end
      1:       begin a1 = av[0];   b1 = bv[0];   s1 = st; end
      default: begin a4 = av[3:0]; b4 = bv[3:0]; s4 = st; end
    endcase
  endtask

  // One complete addition: latency, busy length, hold, result, done width
  task automatic run_op(input int s, input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec, input string tag);
    int edges, busy_cnt;
    sel = s;
    drive(s, av, bv, 1'b1);
    tick();
    drive(s, ~av, ~bv, 1'b0);
    chk({tag, " busy_at_accept"}, 32'(cur_busy), 32'd1);
    chk({tag, " sum_hold"}, 32'(cur_sum), 32'(last_sum[s]));
    chk({tag, " cout_hold"}, 32'(cur_cout), 32'(last_cout[s]));
    busy_cnt = 1;
    edges    = 0;
    while (!cur_done && edges < 40) begin
      tick();
      edges++;
      if (cur_busy) busy_cnt++;
    end
    chk({tag, " done_latency"}, 32'(edges), 32'(w));
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(w));
    chk({tag, " sum"}, 32'(cur_sum), 32'(es));
    chk({tag, " cout"}, 32'(cur_cout), 32'(ec));
    last_sum[s]  = es;
    last_cout[s] = ec;
    tick();
    chk({tag, " done_width"}, 32'(cur_done), 32'd0);
  endtask

  initial begin
    int         pulses, edges;
    logic [7:0] got_sum;
    logic       got_cout;
    logic [7:0] p, q;
    logic [4:0] e4;

    for (int k = 0; k < 3; k++) begin
      last_sum[k]  = '0;
      last_cout[k] = 1'b0;
    end

    // Reset state, before any clock edge
    #2;
    chk("reset busy8/done8", {30'd0, busy8, done8}, 32'd0);
    chk("reset sum8/cout8", {23'd0, cout8, sum8}, 32'd0);
    chk("reset w1 outputs", {28'd0, busy1, done1, sum1, cout1}, 32'd0);
    chk("reset w4 outputs", {25'd0, busy4, done4, cout4, sum4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(0, 8, 8'h05, 8'h03, 8'h08, 1'b0, "w8 05+03");
    run_op(0, 8, 8'hFF, 8'h01, 8'h00, 1'b1, "w8 FF+01");
    run_op(0, 8, 8'hFF, 8'hFF, 8'hFE, 1'b1, "w8 FF+FF");
    run_op(0, 8, 8'h80, 8'h7F, 8'hFF, 1'b0, "w8 80+7F");

    // Start during SHIFT must be ignored
    sel = 0;
    drive(0, 8'h10, 8'h20, 1'b1);
    tick();
    drive(0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    drive(0, 8'hFF, 8'hFF, 1'b1);
    tick();
    drive(0, 8'hFF, 8'hFF, 1'b0);
    pulses   = 0;
    got_sum  = 8'hXX;
    got_cout = 1'bx;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done8) begin
        pulses++;
        got_sum  = sum8;
        got_cout = cout8;
      end
    end
    chk("ignored start pulses", 32'(pulses), 32'd1);
    chk("ignored start sum", 32'(got_sum), 32'h30);
    chk("ignored start cout", 32'(got_cout), 32'd0);

    // Asynchronous reset in the middle of an operation
    drive(0, 8'hAA, 8'h55, 1'b1);
    tick();
    drive(0, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk("midop busy before reset", 32'(busy8), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset busy/done", {30'd0, busy8, done8}, 32'd0);
    chk("async reset sum", 32'(sum8), 32'd0);
    chk("async reset cout", 32'(cout8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done8) pulses++;
    end
    chk("no done after abort", 32'(pulses), 32'd0);
    chk("sum after abort", {23'd0, cout8, sum8}, 32'd0);
    last_sum[0]  = '0;
    last_cout[0] = 1'b0;
    run_op(0, 8, 8'h12, 8'h34, 8'h46, 1'b0, "w8 after reset");

    // WIDTH = 1, all four operand combinations
    run_op(1, 1, 8'd0, 8'd0, 8'd0, 1'b0, "w1 0+0");
    run_op(1, 1, 8'd0, 8'd1, 8'd1, 1'b0, "w1 0+1");
    run_op(1, 1, 8'd1, 8'd0, 8'd1, 1'b0, "w1 1+0");
    run_op(1, 1, 8'd1, 8'd1, 8'd0, 1'b1, "w1 1+1");

    // WIDTH = 4 exhaustive with start held high: acceptances WIDTH+2 edges apart
    sel = 2;
    drive(2, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      p  = 8'(i) >> 4;
      q  = 8'(i) & 8'h0F;
      e4 = 5'(p) + 5'(q);
      tick();
      chk("x4 accept busy", 32'(busy4), 32'd1);
      p = 8'(i + 1) >> 4;
      q = 8'(i + 1) & 8'h0F;
      drive(2, p, q, i < 255);
      edges = 0;
      while (!done4 && edges < 20) begin
        tick();
        edges++;
      end
      chk("x4 latency", 32'(edges), 32'd4);
      chk("x4 result", {27'd0, cout4, sum4}, 32'(e4));
      tick();
      chk("x4 idle gap", {30'd0, busy4, done4}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
